devil_snoop_responder: RTL and testbench
========================================

Name: devil_snoop_responder

Overview:
- Parametrised ACE snoop-channel (AC/CR) responder for the devil FPGA design; successor to the single-window CR-delay trojan.
- Accepts every snoop on AC, buffers it in a FIFO and returns one CR per snoop in order.
- Snoops that match the configured filters get a programmed or fuzzed CRRESP after a programmable delay, in one-shot or continuous mode.
- Adds multiple address windows, queued outstanding snoops, LFSR fuzzing and a hit counter. Configuration comes from the existing AXI-Lite register block.

Parameters:
- ADDR_W, 44, ACADDR width.
- DELAY_W, 16, delay counter width.
- NUM_FLT, 4, number of address filter windows (1..8).
- FIFO_DEPTH, 4, outstanding snoop buffer depth (power of 2, >=2).
- LFSR_SEED, 5'h1F, fuzz LFSR reset value (non-zero).

Ports:
- clk_100MHz  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- acvalid  in  1  snoop address valid.
- acready  out  1  snoop address ready.
- acaddr  in  ADDR_W  snoop address.
- acsnoop  in  4  snoop type.
- crvalid  out  1  snoop response valid.
- crready  in  1  snoop response ready.
- crresp  out  5  snoop response.
- cfg_en  in  1  global enable for hit classification.
- cfg_func  in  1  0 = one-shot, 1 = continuous.
- cfg_test  in  1  0 = fuzz CRRESP, 1 = programmed CRRESP.
- cfg_crresp  in  5  programmed response for hits.
- cfg_delay  in  DELAY_W  cycles added before a hit response.
- cfg_acflt_en  in  1  require acsnoop == cfg_acsnoop.
- cfg_acsnoop  in  4  snoop type to match.
- cfg_addrflt_en  in  1  require address-window match.
- cfg_flt_en  in  NUM_FLT  per-window enable.
- cfg_flt_base  in  NUM_FLT*ADDR_W  window bases; window i at [i*ADDR_W +: ADDR_W].
- cfg_flt_size  in  NUM_FLT*32  window sizes in bytes.
- done_clr  in  1  pulse: clear done, the one-shot latch and hit_cnt.
- done  out  1  one-shot hit response completed.
- hit_cnt  out  32  completed hit responses, saturating.

Behaviour:
- Reset: acready=0 while reset is asserted and 1 after release (FIFO empty); crvalid=0; crresp=0; done=0; hit_cnt=0; FIFO empty; FSM=IDLE; LFSR=LFSR_SEED.
- acready = !fifo_full, driven from the registered full flag. A snoop is accepted on acvalid&&acready and written to the FIFO the same cycle with its hit bit.
- Hit classification happens at acceptance. A snoop is a hit when all of the following hold:
  - cfg_en=1;
  - cfg_acflt_en=0, or acsnoop==cfg_acsnoop;
  - cfg_addrflt_en=0, or some window i has cfg_flt_en[i]=1, size!=0 and base <= acaddr < base+size;
  - cfg_func=1, or the one-shot latch is clear.
- Window compare is done in ADDR_W+1 bits (size zero-extended) so base+size never wraps. Size 0 disables the window.
- One-shot: the latch sets when the first hit is enqueued; later snoops are misses. done sets on the CR handshake of that hit.
- done_clr clears done, the latch and hit_cnt. If done_clr coincides with a set event, the set wins.
- Changing cfg_* never reclassifies entries already queued. cfg_delay and cfg_crresp are sampled when an entry reaches the FIFO head.
- FSM:
  - IDLE: if FIFO non-empty and the head is a hit with cfg_delay>0, load the counter with cfg_delay and go to WAIT; if non-empty otherwise, go to RESP.
  - WAIT: decrement the counter; when it reaches 1, go to RESP.
  - RESP: crvalid=1. crresp is captured on entry and held stable until the handshake. On crvalid&&crready, pop the FIFO and go to IDLE.
- crresp value:
  - miss: 5'b00000;
  - hit with cfg_test=1: cfg_crresp;
  - hit with cfg_test=0: LFSR value at RESP entry.
- LFSR: 5-bit Fibonacci, x^5+x^3+1, steps every cycle while cfg_en=1.
- Latency with an empty FIFO and AC accepted in cycle T:
  - miss: crvalid asserts in T+2;
  - hit: crvalid asserts in T+2+cfg_delay.
- FIFO and flow control:
  - Full: acready=0, no snoop is lost.
  - Simultaneous push and pop while full: not allowed, since acready is already low.
  - Pointers wrap modulo FIFO_DEPTH.
- hit_cnt increments on each hit CR handshake and saturates at 32'hFFFFFFFF.
- Reset mid-operation clears the FIFO, FSM, counter and outputs immediately; crvalid drops asynchronously.

Test Plan:
- Miss path: cfg_en=0, one AC at acaddr=0x2, crready=1 -> crvalid in T+2 with crresp=0; hit_cnt=0.
- Delayed programmed hit: cfg_en=1, cfg_func=1, cfg_test=1, cfg_crresp=5'h09, cfg_delay=2, filters off -> crvalid in T+4 with crresp=0x09; hit_cnt=1.
- One-shot: cfg_func=0, 3 back-to-back ACs -> first response 0x09, next two 0; done=1 after the first CR handshake; done_clr -> done=0, hit_cnt=0, the next AC is a hit again.
- Address filter: window0 base=0x10 size=0x100 enabled; ACs at 0x0F, 0x10, 0x10F, 0x110 -> hit pattern miss, hit, hit, miss; cfg_flt_en=0 -> all miss.
- Backpressure: crready=0, 5 ACs with FIFO_DEPTH=4 -> acready=0 after 4 accepts; crvalid/crresp stable; release crready -> 5 responses in order.
- Fuzz: cfg_test=0, 4 hits with delay 0 -> crresp equals the LFSR sequence from seed 0x1F, never 0; assert reset during WAIT -> crvalid=0, FIFO empty.

Source files
------------

// File: rtl/devil_snoop_responder.sv
// ACE snoop-channel responder: accepts every AC snoop, queues it with its hit
// classification and returns one CR per snoop in order, delayed/fuzzed on hits.
module devil_snoop_responder #(
  parameter int unsigned ADDR_W     = 44,
  parameter int unsigned DELAY_W    = 16,
  parameter int unsigned NUM_FLT    = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [4:0]  LFSR_SEED  = 5'h1F
) (
  input  logic                      clk_100MHz,
  input  logic                      reset,
  input  logic                      acvalid,
  output logic                      acready,
  input  logic [ADDR_W-1:0]         acaddr,
  input  logic [3:0]                acsnoop,
  output logic                      crvalid,
  input  logic                      crready,
  output logic [4:0]                crresp,
  input  logic                      cfg_en,
  input  logic                      cfg_func,
  input  logic                      cfg_test,
  input  logic [4:0]                cfg_crresp,
  input  logic [DELAY_W-1:0]        cfg_delay,
  input  logic                      cfg_acflt_en,
  input  logic [3:0]                cfg_acsnoop,
  input  logic                      cfg_addrflt_en,
  input  logic [NUM_FLT-1:0]        cfg_flt_en,
  input  logic [NUM_FLT*ADDR_W-1:0] cfg_flt_base,
  input  logic [NUM_FLT*32-1:0]     cfg_flt_size,
  input  logic                      done_clr,
  output logic                      done,
  output logic [31:0]               hit_cnt
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned CMP_W = ADDR_W + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

  state_e              state_q, state_d;
  logic [DELAY_W-1:0]  cnt_q, cnt_d;
  logic                acready_q, acready_d;
  logic                crvalid_q, crvalid_d;
  logic [4:0]          crresp_q, crresp_d;
  logic                done_q, done_d;
  logic [31:0]         hit_cnt_q, hit_cnt_d;
  logic                latch_q, latch_d;
  logic [4:0]          lfsr_q, lfsr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [FIFO_DEPTH-1:0] mem_hit_q, mem_hit_d, mem_os_q, mem_os_d;

  logic               push_c, pop_c, head_hit_c, head_os_c, ac_hit_c;
  logic [4:0]         resp_val_c;
  logic [CMP_W-1:0]   addr_ext_c;
  logic [NUM_FLT-1:0] win_match_c;

  assign acready = acready_q;
  assign crvalid = crvalid_q;
  assign crresp  = crresp_q;
  assign done    = done_q;
  assign hit_cnt = hit_cnt_q;

  assign push_c     = acvalid && acready_q;
  assign pop_c      = (state_q == ST_RESP) && crready;
  assign head_hit_c = mem_hit_q[rd_ptr_q];
  assign head_os_c  = mem_os_q[rd_ptr_q];
  assign addr_ext_c = {1'b0, acaddr};

  // Window compare one bit wider than the address so base+size never wraps.
  for (genvar i = 0; i < NUM_FLT; i++) begin : g_win
    logic [CMP_W-1:0] lo_c, size_c, hi_c;
    assign lo_c   = {1'b0, cfg_flt_base[i*ADDR_W +: ADDR_W]};
    assign size_c = CMP_W'(cfg_flt_size[i*32 +: 32]);
    assign hi_c   = lo_c + size_c;
    assign win_match_c[i] = cfg_flt_en[i] && (size_c != '0) &&
                            (addr_ext_c >= lo_c) && (addr_ext_c < hi_c);
  end

  assign ac_hit_c = cfg_en &&
                    (!cfg_acflt_en || (acsnoop == cfg_acsnoop)) &&
                    (!cfg_addrflt_en || (|win_match_c)) &&
                    (cfg_func || !latch_q);

  assign resp_val_c = !head_hit_c ? 5'b00000 : (cfg_test ? cfg_crresp : lfsr_q);

  // Outstanding-snoop FIFO: only the hit/one-shot tags need storing.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    mem_hit_d = mem_hit_q;
    mem_os_d  = mem_os_q;
    if (push_c) begin
      mem_hit_d[wr_ptr_q] = ac_hit_c;
      mem_os_d[wr_ptr_q]  = ac_hit_c && !cfg_func;
      wr_ptr_d            = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    acready_d = (count_d != CNT_W'(FIFO_DEPTH));
  end

  // Status: a clear and a coincident set resolve in favour of the set.
  always_comb begin
    latch_d   = done_clr ? 1'b0 : latch_q;
    done_d    = done_clr ? 1'b0 : done_q;
    hit_cnt_d = done_clr ? 32'd0 : hit_cnt_q;
    if (push_c && ac_hit_c && !cfg_func) begin
      latch_d = 1'b1;
    end
    if (pop_c && head_os_c) begin
      done_d = 1'b1;
    end
    if (pop_c && head_hit_c && (hit_cnt_d != 32'hFFFF_FFFF)) begin
      hit_cnt_d = hit_cnt_d + 32'd1;
    end
    lfsr_d = cfg_en ? {lfsr_q[3:0], lfsr_q[4] ^ lfsr_q[2]} : lfsr_q;
  end

  // Response FSM: crresp is captured on the transition into RESP.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    crvalid_d = crvalid_q;
    crresp_d  = crresp_q;
    unique case (state_q)
      ST_IDLE: begin
        if (count_q != '0) begin
          if (head_hit_c && (cfg_delay != '0)) begin
            cnt_d   = cfg_delay;
            state_d = ST_WAIT;
          end else begin
            state_d   = ST_RESP;
            crvalid_d = 1'b1;
            crresp_d  = resp_val_c;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == DELAY_W'(1)) begin
          state_d   = ST_RESP;
          crvalid_d = 1'b1;
          crresp_d  = resp_val_c;
        end else begin
          cnt_d = cnt_q - DELAY_W'(1);
        end
      end
      ST_RESP: begin
        if (crready) begin
          state_d   = ST_IDLE;
          crvalid_d = 1'b0;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        crvalid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acready_q <= 1'b0;
      crvalid_q <= 1'b0;
      crresp_q  <= 5'b00000;
      done_q    <= 1'b0;
      hit_cnt_q <= 32'd0;
      latch_q   <= 1'b0;
      lfsr_q    <= LFSR_SEED;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      mem_hit_q <= '0;
      mem_os_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acready_q <= acready_d;
      crvalid_q <= crvalid_d;
      crresp_q  <= crresp_d;
      done_q    <= done_d;
      hit_cnt_q <= hit_cnt_d;
      latch_q   <= latch_d;
      lfsr_q    <= lfsr_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      mem_hit_q <= mem_hit_d;
      mem_os_q  <= mem_os_d;
    end
  end

endmodule

// File: tb/tb_devil_snoop_responder.sv
// Bench for devil_snoop_responder: directed scenarios plus random traffic,
// checked every cycle against a transaction-level model of the responder.
module tb_devil_snoop_responder;

  localparam int unsigned ADDR_W     = 44;
  localparam int unsigned DELAY_W    = 16;
  localparam int unsigned NUM_FLT    = 4;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam logic [4:0]  SEED       = 5'h1F;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic acvalid = 1'b0;
  logic acready;
  logic [ADDR_W-1:0] acaddr = '0;
  logic [3:0] acsnoop = '0;
  logic crvalid;
  logic crready = 1'b1;
  logic [4:0] crresp;
  logic cfg_en = 1'b0, cfg_func = 1'b0, cfg_test = 1'b0;
  logic [4:0] cfg_crresp = '0;
  logic [DELAY_W-1:0] cfg_delay = '0;
  logic cfg_acflt_en = 1'b0;
  logic [3:0] cfg_acsnoop = '0;
  logic cfg_addrflt_en = 1'b0;
  logic [NUM_FLT-1:0] cfg_flt_en = '0;
  logic [NUM_FLT*ADDR_W-1:0] cfg_flt_base = '0;
  logic [NUM_FLT*32-1:0] cfg_flt_size = '0;
  logic done_clr = 1'b0;
  logic done;
  logic [31:0] hit_cnt;

  always #5 clk = ~clk;

  devil_snoop_responder #(
    .ADDR_W(ADDR_W), .DELAY_W(DELAY_W), .NUM_FLT(NUM_FLT),
    .FIFO_DEPTH(FIFO_DEPTH), .LFSR_SEED(SEED)
  ) dut (
    .clk_100MHz(clk), .reset(reset),
    .acvalid(acvalid), .acready(acready), .acaddr(acaddr), .acsnoop(acsnoop),
    .crvalid(crvalid), .crready(crready), .crresp(crresp),
    .cfg_en(cfg_en), .cfg_func(cfg_func), .cfg_test(cfg_test),
    .cfg_crresp(cfg_crresp), .cfg_delay(cfg_delay),
    .cfg_acflt_en(cfg_acflt_en), .cfg_acsnoop(cfg_acsnoop),
    .cfg_addrflt_en(cfg_addrflt_en), .cfg_flt_en(cfg_flt_en),
    .cfg_flt_base(cfg_flt_base), .cfg_flt_size(cfg_flt_size),
    .done_clr(done_clr), .done(done), .hit_cnt(hit_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { logic hit; logic os; } ent_t;
  ent_t        mq[$];
  logic        m_acready, m_crvalid, m_done, m_latch, m_sched;
  logic [4:0]  m_crresp, m_lfsr;
  logic [31:0] m_hit_cnt;
  int          m_resp_at;

  int         acc_cyc[$];
  int         hs_cyc[$];
  logic [4:0] hs_resp[$];

  function automatic logic classify(input logic [ADDR_W-1:0] a, input logic [3:0] s);
    logic win;
    longint unsigned av;
    win = 1'b0;
    av  = longint'(a);
    for (int i = 0; i < NUM_FLT; i++) begin
      longint unsigned b, z;
      b = longint'(cfg_flt_base[i*ADDR_W +: ADDR_W]);
      z = longint'(cfg_flt_size[i*32 +: 32]);
      if (cfg_flt_en[i] && z != 0 && av >= b && av < b + z) win = 1'b1;
    end
    return cfg_en && (!cfg_acflt_en || s == cfg_acsnoop) &&
           (!cfg_addrflt_en || win) && (cfg_func || !m_latch);
  endfunction

  always @(negedge clk) begin : p_model
    logic hs, acc, hit, nxt_crvalid;
    ent_t e;
    if (reset) begin
      mq.delete();
      m_acready = 1'b0; m_crvalid = 1'b0; m_crresp = 5'd0; m_done = 1'b0;
      m_hit_cnt = 32'd0; m_latch = 1'b0; m_lfsr = SEED; m_sched = 1'b0; m_resp_at = 0;
    end
    chk("acready", 32'(acready), 32'(m_acready));
    chk("crvalid", 32'(crvalid), 32'(m_crvalid));
    if (m_crvalid || reset) chk("crresp", 32'(crresp), 32'(m_crresp));
    chk("done", 32'(done), 32'(m_done));
    chk("hit_cnt", hit_cnt, m_hit_cnt);
    if (!reset) begin
      if (crvalid && crready) begin hs_cyc.push_back(cyc); hs_resp.push_back(crresp); end
      if (acvalid && acready) acc_cyc.push_back(cyc);
      hs  = m_crvalid && crready;
      acc = acvalid && m_acready;
      hit = classify(acaddr, acsnoop);
      nxt_crvalid = m_crvalid;
      if (done_clr) begin m_done = 1'b0; m_latch = 1'b0; m_hit_cnt = 32'd0; end
      if (hs) begin
        e = mq.pop_front();
        if (e.hit && m_hit_cnt != 32'hFFFF_FFFF) m_hit_cnt = m_hit_cnt + 1;
        if (e.os) m_done = 1'b1;
        nxt_crvalid = 1'b0;
        m_sched = 1'b0;
      end else if (!m_sched && mq.size() > 0) begin
        m_sched   = 1'b1;
        m_resp_at = cyc + 1 + (mq[0].hit ? int'(cfg_delay) : 0);
      end
      if (m_sched && !m_crvalid && m_resp_at == cyc + 1) begin
        nxt_crvalid = 1'b1;
        m_crresp = !mq[0].hit ? 5'd0 : (cfg_test ? cfg_crresp : m_lfsr);
      end
      if (acc) begin
        e.hit = hit;
        e.os  = hit && !cfg_func;
        if (e.os) m_latch = 1'b1;
        mq.push_back(e);
      end
      m_crvalid = nxt_crvalid;
      m_acready = (mq.size() < FIFO_DEPTH);
      if (cfg_en) m_lfsr = {m_lfsr[3:0], m_lfsr[4] ^ m_lfsr[2]};
    end
    cyc++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_obs();
    acc_cyc.delete(); hs_cyc.delete(); hs_resp.delete();
  endtask

  task automatic send(input logic [ADDR_W-1:0] a, input logic [3:0] s);
    logic rdy;
    int k;
    acvalid = 1'b1; acaddr = a; acsnoop = s; k = 0;
    do begin rdy = acready; tick(); k++; end while (!rdy && k < 200);
    acvalid = 1'b0;
    if (!rdy) chk("send_accept", 32'(rdy), 32'd1);
  endtask

  task automatic wait_resp(input int n);
    int k;
    k = 0;
    while (hs_resp.size() < n && k < 500) begin tick(); k++; end
    chk("resp_count", 32'(hs_resp.size()), 32'(n));
  endtask

  task automatic chk_resp(input string name, input int idx, input logic [4:0] exp);
    if (idx < hs_resp.size()) chk(name, 32'(hs_resp[idx]), 32'(exp));
    else chk({name, "_missing"}, 32'(hs_resp.size()), 32'(idx + 1));
  endtask

  task automatic chk_lat(input string name, input int idx, input int exp);
    if (idx < hs_cyc.size() && idx < acc_cyc.size())
      chk(name, 32'(hs_cyc[idx] - acc_cyc[idx]), 32'(exp));
    else chk({name, "_missing"}, 32'(hs_cyc.size()), 32'(idx + 1));
  endtask

  task automatic randomize_cfg();
    cfg_en         = ($urandom_range(0, 7) != 0);
    cfg_func       = 1'($urandom_range(0, 1));
    cfg_test       = 1'($urandom_range(0, 1));
    cfg_crresp     = 5'($urandom);
    cfg_delay      = DELAY_W'($urandom_range(0, 3));
    cfg_acflt_en   = 1'($urandom_range(0, 1));
    cfg_acsnoop    = 4'($urandom_range(0, 3));
    cfg_addrflt_en = 1'($urandom_range(0, 1));
    cfg_flt_en     = NUM_FLT'($urandom);
    for (int i = 0; i < 3; i++) begin
      cfg_flt_base[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 'h200));
      cfg_flt_size[i*32 +: 32] = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 'h100));
    end
    cfg_flt_base[3*ADDR_W +: ADDR_W] = 44'hFFF_FFFF_FFC0;
    cfg_flt_size[3*32 +: 32] = 32'h100;
  endtask

  initial begin : p_watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : p_main
    repeat (3) tick();
    chk("rst_acready", 32'(acready), 32'd0);
    chk("rst_crvalid", 32'(crvalid), 32'd0);
    chk("rst_crresp", 32'(crresp), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_hit_cnt", hit_cnt, 32'd0);
    reset = 1'b0;
    repeat (2) tick();
    chk("post_rst_acready", 32'(acready), 32'd1);

    // Miss path
    clear_obs();
    send(44'h2, 4'h0);
    wait_resp(1);
    chk_lat("miss_latency", 0, 2);
    chk_resp("miss_resp", 0, 5'h00);
    chk("miss_hit_cnt", hit_cnt, 32'd0);

    // Delayed programmed hit
    cfg_en = 1'b1; cfg_func = 1'b1; cfg_test = 1'b1; cfg_crresp = 5'h09; cfg_delay = 16'd2;
    clear_obs();
    send(44'h2, 4'h0);
    wait_resp(1);
    chk_lat("hit_latency", 0, 4);
    chk_resp("hit_resp", 0, 5'h09);
    chk("hit_hit_cnt", hit_cnt, 32'd1);

    // One-shot
    cfg_delay = 16'd0; cfg_func = 1'b0;
    done_clr = 1'b1; tick(); done_clr = 1'b0;
    clear_obs();
    send(44'h20, 4'h0); send(44'h24, 4'h0); send(44'h28, 4'h0);
    wait_resp(3);
    chk_resp("os_resp0", 0, 5'h09);
    chk_resp("os_resp1", 1, 5'h00);
    chk_resp("os_resp2", 2, 5'h00);
    chk("os_done", 32'(done), 32'd1);
    chk("os_hit_cnt", hit_cnt, 32'd1);
    done_clr = 1'b1; tick(); done_clr = 1'b0;
    chk("os_clr_done", 32'(done), 32'd0);
    chk("os_clr_hit_cnt", hit_cnt, 32'd0);
    clear_obs();
    send(44'h30, 4'h0);
    wait_resp(1);
    chk_resp("os_rearm_resp", 0, 5'h09);

    // Address window filter
    cfg_func = 1'b1; cfg_addrflt_en = 1'b1; cfg_flt_en = 4'b0001;
    cfg_flt_base[0 +: ADDR_W] = 44'h10; cfg_flt_size[0 +: 32] = 32'h100;
    clear_obs();
    send(44'h0F, 4'h0); send(44'h10, 4'h0); send(44'h10F, 4'h0); send(44'h110, 4'h0);
    wait_resp(4);
    chk_resp("win_0f", 0, 5'h00);
    chk_resp("win_10", 1, 5'h09);
    chk_resp("win_10f", 2, 5'h09);
    chk_resp("win_110", 3, 5'h00);
    cfg_flt_en = 4'b0000;
    clear_obs();
    send(44'h10, 4'h0); send(44'h50, 4'h0);
    wait_resp(2);
    chk_resp("win_off0", 0, 5'h00);
    chk_resp("win_off1", 1, 5'h00);

    // Backpressure with a full FIFO
    cfg_addrflt_en = 1'b0; cfg_acflt_en = 1'b1; cfg_acsnoop = 4'h1; crready = 1'b0;
    clear_obs();
    send(44'h100, 4'h1); send(44'h104, 4'h0); send(44'h108, 4'h1); send(44'h10C, 4'h0);
    acvalid = 1'b1; acaddr = 44'h110; acsnoop = 4'h1;
    repeat (3) tick();
    chk("bp_acready", 32'(acready), 32'd0);
    chk("bp_accepts", 32'(acc_cyc.size()), 32'd4);
    chk("bp_crvalid", 32'(crvalid), 32'd1);
    chk("bp_crresp", 32'(crresp), 32'h09);
    crready = 1'b1;
    send(44'h110, 4'h1);
    wait_resp(5);
    chk_resp("bp_r0", 0, 5'h09);
    chk_resp("bp_r1", 1, 5'h00);
    chk_resp("bp_r2", 2, 5'h09);
    chk_resp("bp_r3", 3, 5'h00);
    chk_resp("bp_r4", 4, 5'h09);

    // Fuzzed responses straight after a reset
    cfg_acflt_en = 1'b0; cfg_test = 1'b0;
    reset = 1'b1; tick();
    reset = 1'b0;
    clear_obs();
    send(44'h0, 4'h0);
    wait_resp(1);
    chk_resp("fuzz_first", 0, 5'h1C);
    send(44'h4, 4'h0); send(44'h8, 4'h0); send(44'hC, 4'h0);
    wait_resp(4);
    for (int i = 1; i < 4; i++)
      if (i < hs_resp.size()) chk("fuzz_nonzero", 32'(hs_resp[i] != 5'd0), 32'd1);

    // Reset while waiting out a delay
    cfg_test = 1'b1; cfg_delay = 16'd20;
    send(44'h0, 4'h0);
    repeat (5) tick();
    chk("wait_crvalid", 32'(crvalid), 32'd0);
    reset = 1'b1; #1;
    chk("wait_rst_acready", 32'(acready), 32'd0);
    chk("wait_rst_crvalid", 32'(crvalid), 32'd0);
    tick(); reset = 1'b0; repeat (2) tick();
    cfg_en = 1'b0;
    clear_obs();
    send(44'h0, 4'h0);
    wait_resp(1);
    chk_lat("after_rst_latency", 0, 2);
    repeat (30) tick();
    chk("after_rst_only_one", 32'(hs_resp.size()), 32'd1);

    // Reset while a response is held by backpressure
    cfg_en = 1'b1; cfg_delay = 16'd0; crready = 1'b0;
    send(44'h0, 4'h0);
    repeat (3) tick();
    chk("resp_hold_crvalid", 32'(crvalid), 32'd1);
    #1 reset = 1'b1; #1;
    chk("async_drop_crvalid", 32'(crvalid), 32'd0);
    tick(); reset = 1'b0; crready = 1'b1;
    repeat (2) tick();

    // Random traffic against the model
    randomize_cfg();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 49) == 0) randomize_cfg();
      acvalid  = 1'($urandom_range(0, 1));
      acaddr   = ($urandom_range(0, 3) == 0) ? (44'hFFF_FFFF_FF00 + ADDR_W'($urandom_range(0, 255)))
                                            : ADDR_W'($urandom_range(0, 'h300));
      acsnoop  = 4'($urandom_range(0, 3));
      crready  = ($urandom_range(0, 9) < 7);
      done_clr = ($urandom_range(0, 49) == 0);
      tick();
    end
    acvalid = 1'b0; done_clr = 1'b0; crready = 1'b1;
    repeat (100) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
